pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core. Combines stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector that every pipeline register consumes. It sequences exception flushes through a small state machine and supplies the redirect PC. It also guards against a hung data bus with a MEM-stall watchdog and counts stalled cycles for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_wdog.sv | 35 +++
 rtl/pipe_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, state encoding and stall encoder for pipe_ctrl
package pipe_ctrl_pkg;

  // Reset level and common word values
  localparam logic        RstEnable = 1'b0;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Stall masks: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallNone = 6'b000000;

  typedef enum logic [1:0] {
    CtrlRun     = 2'd0,
    CtrlFlush   = 2'd1,
    CtrlRecover = 2'd2
  } ctrl_state_e;

  // The furthest-along requesting stage decides how much of the pipe freezes
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    if (req_mem)     return StallMem;
    else if (req_ex) return StallEx;
    else if (req_id) return StallId;
    else if (req_if) return StallIf;
    else             return StallNone;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// rtl/pipe_ctrl_wdog.sv - MEM-stall watchdog counter for pipe_ctrl
module ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req,
  output logic expire
);

  // TIMEOUT of zero turns the watchdog off entirely
  localparam logic        Enabled   = (TIMEOUT != 0);
  localparam logic [15:0] LastCount = Enabled ? 16'(TIMEOUT - 1) : 16'h0000;

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Count consecutive stalled cycles; any gap or leaving RUN restarts the count
  always_comb begin
    cnt_d = 16'h0000;
    if (en && req) cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= 16'h0000;
    else                  cnt_q <= cnt_d;
  end

  assign expire = Enabled && en && req && (cnt_q == LastCount);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with bus watchdog and stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [31:0] TIMEOUT_VEC = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] exc_vec,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cycles
);

  ctrl_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        to_q, to_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        wdog_expire;

  ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == CtrlRun),
    .req    (stallreq_mem),
    .expire (wdog_expire)
  );

  // Next state, latched redirect target and combinational stall vector
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    to_d    = to_q;
    stall   = StallNone;
    case (state_q)
      CtrlRun: begin
        stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        // A committed exception wins over a simultaneous watchdog expiry
        if (flush_req) begin
          state_d = CtrlFlush;
          pc_d    = exc_vec;
          to_d    = 1'b0;
        end else if (wdog_expire) begin
          state_d = CtrlFlush;
          pc_d    = TIMEOUT_VEC;
          to_d    = 1'b1;
        end
      end
      CtrlFlush:   state_d = CtrlRecover;
      // Requests from squashed stages are ignored here so they cannot act
      CtrlRecover: state_d = CtrlRun;
      default:     state_d = CtrlRun;
    endcase
  end

  // FSM state and redirect registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= CtrlRun;
      pc_q    <= ZeroWord;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      to_q    <= to_d;
    end
  end

  assign flush       = (state_q == CtrlFlush);
  assign new_pc      = flush ? pc_q : ZeroWord;
  assign bus_timeout = flush && to_q;

  // Saturating count of cycles where the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] == Stop && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Performance counter register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) stall_cnt_q <= ZeroWord;
    else                  stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;

endmodule
